// File: rtl/mul_div_seq_ctrl.sv
// Iterative multiply/divide sequencer reusing one WIDTH-cell array row over WIDTH cycles.
// Latency from accepted start: mul WIDTH+1, div WIDTH+2, divide-by-zero 1 cycle to done.
// No backpressure: start is only sampled in IDLE; starts while busy are dropped, never queued.
module mul_div_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mul_bar,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result_hi,
    output logic [WIDTH-1:0]         result_lo,
    output logic                     div_by_zero,
    output logic [$clog2(WIDTH)-1:0] row_idx,
    output logic                     row_p
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state;
    logic             op_div;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   acc;   // mul: partial product high half; div: signed remainder
    logic [WIDTH-1:0] q;     // mul: multiplier / product low half; div: dividend / quotient

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_acc_nx;
    logic [WIDTH-1:0] mul_q_nx;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_r_nx;
    logic [WIDTH-1:0] div_q_nx;
    logic [WIDTH:0]   fix_r;

    always_comb begin
        mul_sum    = acc + (q[0] ? {1'b0, b_q} : '0);
        mul_acc_nx = {1'b0, mul_sum[WIDTH:1]};
        mul_q_nx   = {mul_sum[0], q[WIDTH-1:1]};
        // Wraps modulo 2^(WIDTH+1); the +/-B step always lands back in range.
        div_sh     = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_r_nx   = acc[WIDTH] ? (div_sh + {1'b0, b_q}) : (div_sh - {1'b0, b_q});
        div_q_nx   = {q[WIDTH-2:0], ~div_r_nx[WIDTH]};
        fix_r      = acc[WIDTH] ? (acc + {1'b0, b_q}) : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_div      <= 1'b0;
            b_q         <= '0;
            acc         <= '0;
            q           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
            row_idx     <= '0;
            row_p       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_div      <= mul_bar;
                        b_q         <= b;
                        q           <= a;
                        acc         <= '0;
                        div_by_zero <= 1'b0;
                        row_idx     <= '0;
                        if (mul_bar && (b == '0)) begin
                            state       <= FIN;
                            done        <= 1'b1;
                            result_hi   <= a;
                            result_lo   <= '1;
                            div_by_zero <= 1'b1;
                            row_p       <= 1'b0;
                        end else begin
                            state <= ITER;
                            busy  <= 1'b1;
                            // Remainder starts at 0 (non-negative), so a divide opens with subtract.
                            row_p <= mul_bar;
                        end
                    end
                end
                ITER: begin
                    if (op_div) begin
                        acc <= div_r_nx;
                        q   <= div_q_nx;
                    end else begin
                        acc <= mul_acc_nx;
                        q   <= mul_q_nx;
                    end
                    if (row_idx == IW'(WIDTH - 1)) begin
                        row_idx <= '0;
                        row_p   <= 1'b0;
                        if (op_div) begin
                            state <= FIX;
                        end else begin
                            state     <= FIN;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            result_hi <= mul_acc_nx[WIDTH-1:0];
                            result_lo <= mul_q_nx;
                        end
                    end else begin
                        row_idx <= row_idx + IW'(1);
                        row_p   <= op_div & ~div_r_nx[WIDTH];
                    end
                end
                FIX: begin
                    acc       <= fix_r;
                    state     <= FIN;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    result_hi <= fix_r[WIDTH-1:0];
                    result_lo <= q;
                    row_p     <= 1'b0;
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_seq_ctrl.sv
// Scoreboard bench for mul_div_seq_ctrl: expected results are queued at issue, popped at done.
module tb_mul_div_seq_ctrl;
    localparam int W  = 4;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mul_bar = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, div_by_zero, row_p;
    logic [W-1:0]  result_hi, result_lo;
    logic [IW-1:0] row_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic         is_div;
        int           lat;
        logic [W-1:0] pexp;
    } exp_t;

    exp_t sb[$];

    mul_div_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mul_bar(mul_bar), .a(a), .b(b),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero), .row_idx(row_idx), .row_p(row_p)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic mb, input logic [W-1:0] aa, input logic [W-1:0] bb);
        exp_t e;
        logic [2*W-1:0] prod;
        int r;
        logic p;
        e.pexp = '0;
        e.is_div = mb;
        e.dbz = 1'b0;
        if (!mb) begin
            prod  = (2*W)'(aa) * (2*W)'(bb);
            e.hi  = prod[2*W-1:W];
            e.lo  = prod[W-1:0];
            e.lat = W + 1;
        end else if (bb == '0) begin
            e.hi  = aa;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.hi  = W'(int'(aa) % int'(bb));
            e.lo  = W'(int'(aa) / int'(bb));
            e.lat = W + 2;
            r = 0;
            for (int i = 0; i < W; i++) begin
                p = (r >= 0);
                r = 2 * r + int'(aa[W-1-i]);
                r = p ? r - int'(bb) : r + int'(bb);
                e.pexp[i] = p;
            end
        end
        return e;
    endfunction

    // Issues one operation, optionally pulsing start at the cycles flagged in pulse_mask.
    task automatic run_op(input logic mb, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [31:0] pulse_mask, input string name);
        exp_t e;
        exp_t got;
        int cyc;
        logic [W-1:0] hold_hi, hold_lo;
        e = model(mb, aa, bb);
        sb.push_back(e);
        start = 1'b1; mul_bar = mb; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0; a = ~aa; b = ~bb; mul_bar = ~mb;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc %0d: got %b want 1", name, cyc, busy);
            end
            if (cyc == 1) begin
                checks++;
                if (div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL %s dbz_clear: got %b want 0", name, div_by_zero);
                end
            end
            if (cyc <= W) begin
                checks++;
                if (row_idx !== IW'(cyc - 1) || row_p !== e.pexp[cyc-1]) begin
                    errors++;
                    $display("FAIL %s row cyc %0d: got idx %0d p %b want idx %0d p %b",
                             name, cyc, row_idx, row_p, cyc - 1, e.pexp[cyc-1]);
                end
            end else begin
                checks++;
                if (row_p !== 1'b0) begin
                    errors++;
                    $display("FAIL %s fix_row_p: got %b want 0", name, row_p);
                end
            end
            start = (cyc < 32) ? pulse_mask[cyc] : 1'b0;
            if (start) begin
                a = W'($urandom); b = W'($urandom); mul_bar = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
            void'(sb.pop_front());
        end else begin
            got = sb.pop_front();
            if (cyc !== got.lat || result_hi !== got.hi || result_lo !== got.lo ||
                div_by_zero !== got.dbz || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s result: got lat %0d hi %h lo %h dbz %b busy %b want lat %0d hi %h lo %h dbz %b busy 0",
                         name, cyc, result_hi, result_lo, div_by_zero, busy,
                         got.lat, got.hi, got.lo, got.dbz);
            end
            hold_hi = got.hi; hold_lo = got.lo;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || result_hi !== hold_hi || result_lo !== hold_lo ||
                div_by_zero !== got.dbz) begin
                errors++;
                $display("FAIL %s hold: got done %b hi %h lo %h dbz %b want done 0 hi %h lo %h dbz %b",
                         name, done, result_hi, result_lo, div_by_zero, hold_hi, hold_lo, got.dbz);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, result_hi, result_lo, div_by_zero, row_idx, row_p} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy %b done %b hi %h lo %h dbz %b idx %0d p %b want all 0",
                     busy, done, result_hi, result_lo, div_by_zero, row_idx, row_p);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_op(1'b0, 4'd13, 4'd11, 32'h0, "mul_13x11");
        run_op(1'b0, 4'd15, 4'd15, 32'h0, "mul_15x15");
        run_op(1'b0, 4'd0,  4'd9,  32'h0, "mul_0x9");
        run_op(1'b0, 4'd7,  4'd1,  32'h0, "mul_7x1");
    endtask

    task automatic test_div();
        run_op(1'b1, 4'd13, 4'd3,  32'h0, "div_13_3");
        run_op(1'b1, 4'd2,  4'd7,  32'h0, "div_2_7");
        run_op(1'b1, 4'd15, 4'd1,  32'h0, "div_15_1");
        run_op(1'b1, 4'd14, 4'd15, 32'h0, "div_14_15");
        run_op(1'b1, 4'd15, 4'd15, 32'h0, "div_15_15");
    endtask

    task automatic test_div_by_zero();
        run_op(1'b1, 4'd9, 4'd0, 32'h0, "div_9_0");
        run_op(1'b0, 4'd2, 4'd3, 32'h0, "mul_after_dbz");
    endtask

    task automatic test_start_ignored();
        run_op(1'b0, 4'd13, 4'd11, 32'h14, "mul_ignore_start");
        run_op(1'b1, 4'd11, 4'd4,  32'h3e, "div_ignore_start");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_op(1'($urandom), W'($urandom), W'($urandom), 32'h0, "random");
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        saw_done = 1'b0;
        start = 1'b1; mul_bar = 1'b1; a = 4'd13; b = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result_hi, result_lo, div_by_zero, row_idx, row_p} !== '0) begin
            errors++;
            $display("FAIL reset_abort: got busy %b done %b hi %h lo %h dbz %b idx %0d p %b want all 0",
                     busy, done, result_hi, result_lo, div_by_zero, row_idx, row_p);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        run_op(1'b0, 4'd3, 4'd5, 32'h0, "mul_after_abort");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_start_ignored();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
